rx_word_aligner: RTL and testbench

- Receive-side front end for the 8b/10b serial link. Consumes the 1-bit serial stream produced by the transmit serializer and locates 10-bit symbol boundaries by hunting for K28.5 commas.
- Emits aligned 10-bit code groups, with a valid strobe, to the downstream 10b/8b decoder.
- Tracks lock with a HUNT/VERIFY/LOCKED state machine.

---
 rtl/serdes_pkg.sv | 23 ++
 rtl/rx_word_aligner_if.sv | 51 +++++
 rtl/rx_word_aligner_comma_detect.sv | 19 +
 rtl/rx_word_aligner.sv | 167 ++++++++++++++++
 tb/tb_rx_word_aligner.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serdes_pkg.sv
// ============================================================================
// Module      : serdes_pkg
// Description : Shared 8b/10b link constants and the aligner state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serdes_pkg;

  localparam int WORD_W = 10;

  localparam logic [WORD_W-1:0] K28_5_RDN = 10'h17C;
  localparam logic [WORD_W-1:0] K28_5_RDP = 10'h283;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

endpackage

`default_nettype wire

// File: rtl/rx_word_aligner_if.sv
// ============================================================================
// Module      : rx_word_aligner_if
// Description : Serial-in / aligned-word-out bundle of the receive aligner.
//               o_Err_Cnt exists only when RX_ALIGN_ERR_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rx_word_aligner_if;
  import serdes_pkg::*;

  logic              i_Bit_Valid;
  logic              i_Ser_Data;
  logic [WORD_W-1:0] o_10B;
  logic              o_Word_Valid;
  logic              o_Comma;
  logic              o_Locked;
  logic              o_Realign;
`ifdef RX_ALIGN_ERR_CNT_EN
  logic [15:0]       o_Err_Cnt;
`endif

  modport master (
    output i_Bit_Valid,
    output i_Ser_Data,
    input  o_10B,
    input  o_Word_Valid,
    input  o_Comma,
    input  o_Locked,
    input  o_Realign
`ifdef RX_ALIGN_ERR_CNT_EN
    , input o_Err_Cnt
`endif
  );

  modport slave (
    input  i_Bit_Valid,
    input  i_Ser_Data,
    output o_10B,
    output o_Word_Valid,
    output o_Comma,
    output o_Locked,
    output o_Realign
`ifdef RX_ALIGN_ERR_CNT_EN
    , output o_Err_Cnt
`endif
  );

endinterface

`default_nettype wire

// File: rtl/rx_word_aligner_comma_detect.sv
// ============================================================================
// Module      : comma_detect
// Description : Flags a 10-bit window equal to K28.5 of either disparity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comma_detect
  import serdes_pkg::*;
(
  input  logic [WORD_W-1:0] i_window,
  output logic              o_hit
);

  assign o_hit = (i_window == K28_5_RDN) || (i_window == K28_5_RDP);

endmodule

`default_nettype wire

// File: rtl/rx_word_aligner.sv
// ============================================================================
// Module      : rx_word_aligner
// Description : K28.5 comma hunter and 10-bit word aligner (HUNT/VERIFY/LOCKED).
//               Define RX_ALIGN_ERR_CNT_EN to add the o_Err_Cnt slip counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_word_aligner #(
  parameter int LOCK_COMMAS = 3,
  parameter int LOSS_COMMAS = 2
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  rx_word_aligner_if.slave   bus
);
  import serdes_pkg::*;

  localparam int GOOD_W = $clog2(LOCK_COMMAS + 1);
  localparam int BAD_W  = $clog2(LOSS_COMMAS + 1);
  localparam int CNT_W  = $clog2(WORD_W);

  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COMMAS);
  localparam logic [BAD_W-1:0]  BAD_MAX  = BAD_W'(LOSS_COMMAS);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);

  // Bit 0 of the history would never be read again, so only [9:1] is held.
  logic [WORD_W-1:1] shift_q,     shift_d;
  logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [GOOD_W-1:0] good_q,      good_d;
  logic [BAD_W-1:0]  bad_q,       bad_d;
  align_state_t      state_q,     state_d;
  logic [WORD_W-1:0] word_q,      word_d;
  logic              word_vld_q,  word_vld_d;
  logic              comma_q,     comma_d;
  logic              locked_q,    locked_d;
  logic              realign_q,   realign_d;
`ifdef RX_ALIGN_ERR_CNT_EN
  logic [15:0]       err_q,       err_d;
`endif

  logic [WORD_W-1:0] w_window;
  logic              w_hit;
  logic              w_boundary;
  logic              w_do_realign;

  assign w_window   = {bus.i_Ser_Data, shift_q};
  assign w_boundary = bus.i_Bit_Valid && (bit_cnt_q == LAST_BIT);

  comma_detect u_comma_detect (
    .i_window (w_window),
    .o_hit    (w_hit)
  );

  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    good_d       = good_q;
    bad_d        = bad_q;
    state_d      = state_q;
    word_d       = word_q;
    word_vld_d   = 1'b0;
    comma_d      = 1'b0;
    realign_d    = 1'b0;
    w_do_realign = 1'b0;
`ifdef RX_ALIGN_ERR_CNT_EN
    err_d        = err_q;
`endif

    if (bus.i_Bit_Valid) begin
      shift_d   = w_window[WORD_W-1:1];
      bit_cnt_d = w_boundary ? '0 : bit_cnt_q + 1'b1;

      case (state_q)
        HUNT: begin
          if (w_hit) w_do_realign = 1'b1;
        end
        VERIFY: begin
          if (w_boundary) begin
            word_d     = w_window;
            word_vld_d = 1'b1;
            comma_d    = w_hit;
            if (w_hit) begin
              if (good_q != GOOD_MAX) good_d = good_q + 1'b1;
              if (good_d == GOOD_MAX) state_d = LOCKED;
            end
          end else if (w_hit) begin
            w_do_realign = 1'b1;
          end
        end
        LOCKED: begin
          if (w_boundary) begin
            word_d     = w_window;
            word_vld_d = 1'b1;
            comma_d    = w_hit;
            if (w_hit) bad_d = '0;
          end else if (w_hit) begin
`ifdef RX_ALIGN_ERR_CNT_EN
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
`endif
            if (bad_q >= BAD_MAX - 1'b1) w_do_realign = 1'b1;
            else                         bad_d = bad_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase

      // The comma just completed becomes word 0 of the new phase.
      if (w_do_realign) begin
        bit_cnt_d  = '0;
        word_d     = w_window;
        word_vld_d = 1'b1;
        comma_d    = 1'b1;
        realign_d  = 1'b1;
        good_d     = GOOD_W'(1);
        bad_d      = '0;
        state_d    = VERIFY;
      end
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      state_q    <= HUNT;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      comma_q    <= 1'b0;
      locked_q   <= 1'b0;
      realign_q  <= 1'b0;
`ifdef RX_ALIGN_ERR_CNT_EN
      err_q      <= '0;
`endif
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      state_q    <= state_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
      comma_q    <= comma_d;
      locked_q   <= locked_d;
      realign_q  <= realign_d;
`ifdef RX_ALIGN_ERR_CNT_EN
      err_q      <= err_d;
`endif
    end
  end

  assign bus.o_10B        = word_q;
  assign bus.o_Word_Valid = word_vld_q;
  assign bus.o_Comma      = comma_q;
  assign bus.o_Locked     = locked_q;
  assign bus.o_Realign    = realign_q;
`ifdef RX_ALIGN_ERR_CNT_EN
  assign bus.o_Err_Cnt    = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_word_aligner.sv
// ============================================================================
// Module      : tb_rx_word_aligner
// Description : Randomised scoreboard bench for rx_word_aligner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_word_aligner;

  localparam int LOCK_N = 3;
  localparam int LOSS_N = 2;
  localparam logic [9:0] RDN = 10'h17C;
  localparam logic [9:0] RDP = 10'h283;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_word_aligner_if bus ();

  rx_word_aligner #(
    .LOCK_COMMAS (LOCK_N),
    .LOSS_COMMAS (LOSS_N)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [9:0] word;
    logic       comma;
    logic       realign;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: stream position arithmetic over the received bits.
  bit   hist[$];
  int   m_idx, m_anchor, m_state, m_good, m_bad;
  bit   m_locked, m_zero;
`ifdef RX_ALIGN_ERR_CNT_EN
  int   m_err;
`endif

  logic [9:0] last_word;
  int   strobe_cnt  = 0;
  int   realign_cnt = 0;
  bit   last_b;
  int   run_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void m_push(logic [9:0] w, bit c, bit r);
    exp_t e;
    e.word = w; e.comma = c; e.realign = r;
    exp_q.push_back(e);
  endfunction

  function automatic void model_step(bit r, bit v, bit b);
    bit [9:0] win;
    bit is_c, on_b, do_re;
    if (r) begin
      hist.delete();
      repeat (10) hist.push_back(1'b0);
      m_idx = 0; m_anchor = 0; m_state = 0; m_good = 0; m_bad = 0;
      m_locked = 0; m_zero = 1;
`ifdef RX_ALIGN_ERR_CNT_EN
      m_err = 0;
`endif
      return;
    end
    m_zero = 0;
    if (!v) return;
    hist.push_back(b);
    void'(hist.pop_front());
    for (int k = 0; k < 10; k++) win[k] = hist[k];
    m_idx++;
    is_c  = (win == RDN) || (win == RDP);
    on_b  = ((m_idx - m_anchor) % 10) == 0;
    do_re = 0;
    if (m_state == 0) begin
      do_re = is_c;
    end else if (on_b) begin
      m_push(win, is_c, 1'b0);
      if (is_c) begin
        if (m_state == 1) begin
          if (m_good < LOCK_N) m_good++;
          if (m_good >= LOCK_N) m_state = 2;
        end else begin
          m_bad = 0;
        end
      end
    end else if (is_c) begin
      if (m_state == 1) begin
        do_re = 1;
      end else begin
`ifdef RX_ALIGN_ERR_CNT_EN
        if (m_err < 65535) m_err++;
`endif
        m_bad++;
        if (m_bad >= LOSS_N) do_re = 1;
      end
    end
    if (do_re) begin
      m_anchor = m_idx; m_state = 1; m_good = 1; m_bad = 0;
      m_push(win, 1'b1, 1'b1);
    end
    m_locked = (m_state == 2);
  endfunction

  task automatic send_bit(input bit b, input bit v, input bit r);
    @(negedge clk);
    rst = r;
    bus.i_Bit_Valid = v;
    bus.i_Ser_Data  = b;
    model_step(r, v, b);
    if (v && !r) begin
      if (b == last_b) run_len++;
      else begin run_len = 1; last_b = b; end
    end
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) send_bit(w[i], 1'b1, 1'b0);
  endtask

  task automatic send_word_gaps(input logic [9:0] w);
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 5)) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      send_bit(w[i], 1'b1, 1'b0);
    end
  endtask

  // Random data with runs of at most three, so no stray comma can form.
  function automatic logic [9:0] gen_data();
    logic [9:0] w;
    bit lb = last_b;
    int rl = run_len;
    for (int i = 0; i < 10; i++) begin
      bit x = 1'($urandom_range(0, 1));
      if (rl >= 3 && x == lb) x = ~lb;
      w[i] = x;
      if (x == lb) rl++;
      else begin rl = 1; lb = x; end
    end
    return w;
  endfunction

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (m_zero) begin
      chk("rst_10b", bus.o_10B, 0);
      chk("rst_word_valid", bus.o_Word_Valid, 0);
      chk("rst_comma", bus.o_Comma, 0);
      chk("rst_realign", bus.o_Realign, 0);
      chk("rst_locked", bus.o_Locked, 0);
      last_word = '0;
    end else begin
      chk("locked", bus.o_Locked, m_locked);
`ifdef RX_ALIGN_ERR_CNT_EN
      chk("err_cnt", bus.o_Err_Cnt, m_err);
`endif
      if (bus.o_Realign === 1'b1) realign_cnt++;
      if (bus.o_Word_Valid === 1'b1) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_strobe: actual word=%0h required=no strobe", bus.o_10B);
        end else begin
          e = exp_q.pop_front();
          chk("word", bus.o_10B, e.word);
          chk("word_comma", bus.o_Comma, e.comma);
          chk("word_realign", bus.o_Realign, e.realign);
          last_word = e.word;
        end
      end else begin
        chk("idle_comma", bus.o_Comma, 0);
        chk("idle_realign", bus.o_Realign, 0);
        chk("word_hold", bus.o_10B, last_word);
      end
    end
  end

  task automatic sync_check(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
    chk(name, act_sel, exp);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_Bit_Valid = 1'b1;
    bus.i_Ser_Data  = 1'b0;
    last_b = 1'b0;
    run_len = 0;
    last_word = '0;
    model_step(1'b1, 1'b1, 1'b0);

    // 1: reset while streaming, then idle data in HUNT
    repeat (2) send_bit(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    repeat (3) send_word(gen_data());
    @(posedge clk); #2;
    chk("hunt_no_strobe", strobe_cnt, 0);
    chk("hunt_not_locked", bus.o_Locked, 0);

    // 2: acquisition at an arbitrary phase
    repeat (4) send_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    send_word(RDN);
    for (int w = 1; w < 16; w++) send_word((w % 4 == 0) ? RDN : gen_data());
    @(posedge clk); #2;
    chk("locked_after_acq", bus.o_Locked, 1);
    chk("acq_realign_once", realign_cnt, 1);

    // 3: both disparities on the boundary
    for (int i = 0; i < 8; i++) begin
      send_word((i % 2) ? RDP : RDN);
      send_word(gen_data());
    end
    @(posedge clk); #2;
    chk("locked_both_rd", bus.o_Locked, 1);
    chk("no_realign_both_rd", realign_cnt, 1);

    // 4: one-bit slip while locked
    send_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    repeat (5) send_word(RDN);
    @(posedge clk); #2;
    chk("relocked_after_slip", bus.o_Locked, 1);
    chk("slip_realign", realign_cnt, 2);
`ifdef RX_ALIGN_ERR_CNT_EN
    chk("err_cnt_slips", bus.o_Err_Cnt, 2);
`endif
    repeat (2) send_word(gen_data());

    // 5: random bit gaps
    for (int i = 0; i < 12; i++) send_word_gaps((i % 4 == 3) ? RDN : gen_data());
    @(posedge clk); #2;
    chk("locked_with_gaps", bus.o_Locked, 1);

    // 6: reset mid-word while locked, then reacquire
    repeat (5) send_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    send_bit(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    @(posedge clk); #2;
    chk("locked_after_reset", bus.o_Locked, 0);
`ifdef RX_ALIGN_ERR_CNT_EN
    chk("err_cnt_cleared", bus.o_Err_Cnt, 0);
`endif
    repeat (3) send_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    send_word(RDP);
    for (int w = 1; w < 10; w++) send_word((w % 4 == 0) ? RDP : gen_data());
    @(posedge clk); #2;
    chk("relocked_after_reset", bus.o_Locked, 1);
    chk("reacq_realign", realign_cnt, 3);

    repeat (3) send_bit(1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
